// File: rtl/vga_timing_gen.sv
// VGA raster timing: sync, DE, raw pixel coordinates and line/frame start strobes, 1 CLK registered latency.
// No backpressure; the raster advances only on CE edges and holds otherwise.
module vga_timing_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    output logic        Hsync,
    output logic        Vsync,
    output logic        DE,
    output logic [11:0] Xpos,
    output logic [11:0] Ypos,
    output logic        LineStart,
    output logic        FrameStart
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS_W    = 12'(H_VIS);
    localparam logic [11:0] V_VIS_W    = 12'(V_VIS);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_VIS + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_VIS + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic        SYNC_ACT   = (SYNC_POL != 0);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [11:0] h_nxt;
    logic [11:0] v_nxt;
    logic        h_wrap;
    logic        v_wrap;
    logic        hs_act;
    logic        vs_act;
    logic        h_vis;
    logic        v_vis;
    logic        h_zero;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_nxt  = h_wrap ? 12'd0 : h_cnt + 12'd1;
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? 12'd0 : v_cnt + 12'd1;
        end
        hs_act = (h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END);
        // Vsync depends on the line only, so it naturally switches together with h=0
        vs_act = (v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END);
        h_vis  = (h_cnt < H_VIS_W);
        v_vis  = (v_cnt < V_VIS_W);
        h_zero = (h_cnt == 12'd0);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (CE) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Outputs describe the pre-increment pixel; strobes self-clear on the next CLK edge regardless of CE
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Hsync      <= ~SYNC_ACT;
            Vsync      <= ~SYNC_ACT;
            DE         <= 1'b0;
            Xpos       <= 12'd0;
            Ypos       <= 12'd0;
            LineStart  <= 1'b0;
            FrameStart <= 1'b0;
        end else begin
            LineStart  <= 1'b0;
            FrameStart <= 1'b0;
            if (CE) begin
                Hsync      <= hs_act ? SYNC_ACT : ~SYNC_ACT;
                Vsync      <= vs_act ? SYNC_ACT : ~SYNC_ACT;
                DE         <= h_vis && v_vis;
                Xpos       <= h_cnt;
                Ypos       <= v_cnt;
                LineStart  <= h_zero && v_vis;
                FrameStart <= h_zero && (v_cnt == 12'd0);
            end
        end
    end

endmodule
